// File: rtl/pc_unit.sv
// ---------------------------------------------------------------------------
// pc_unit -- program-counter unit for the RV32 core.
//
// Holds the fetch address and picks the next PC from sequential increment,
// EX-stage redirect, trap entry or trap return. Also provides stall, halt,
// a post-reset boot delay, the saved exception PC (epc) and a check that
// rejects misaligned redirect targets.
//
// Ports:
//   clk           in   1     clock, rising edge
//   reset         in   1     asynchronous, active-high
//   stall         in   1     hold PC this cycle (pipeline hazard)
//   halt          in   1     level; enter HALT, PC frozen until deasserted
//   redirect      in   1     taken branch/jump resolved in EX
//   redirect_pc   in   XLEN  branch/jump target
//   trap          in   1     take exception/interrupt this cycle
//   trap_pc       in   XLEN  PC of faulting instruction, saved into epc
//   trap_vector   in   XLEN  handler address
//   mret          in   1     return from handler to epc
//   pc            out  XLEN  current fetch address (registered)
//   pc_plus_step  out  XLEN  pc + STEP, combinational, wraps
//   fetch_valid   out  1     pc is a valid fetch this cycle (registered)
//   epc           out  XLEN  saved exception PC (registered)
//   misaligned    out  1     one-cycle pulse for a rejected redirect target
//   bad_addr      out  XLEN  last rejected redirect target (registered)
// ---------------------------------------------------------------------------
module pc_unit #(
  parameter int unsigned          XLEN        = 32,
  parameter logic [XLEN-1:0]      RESET_ADDR  = '0,
  parameter int unsigned          STEP        = 4,
  parameter int unsigned          ALIGN_BITS  = 2,
  parameter int unsigned          BOOT_CYCLES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            halt,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            trap,
  input  logic [XLEN-1:0] trap_pc,
  input  logic [XLEN-1:0] trap_vector,
  input  logic            mret,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus_step,
  output logic            fetch_valid,
  output logic [XLEN-1:0] epc,
  output logic            misaligned,
  output logic [XLEN-1:0] bad_addr
);

  // Boot counter counts 0 .. BOOT_CYCLES-1; the edge on which it sits at the
  // last value is the one that moves the unit into RUN.
  localparam int unsigned CNT_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] BOOT_LAST = CNT_W'(BOOT_CYCLES - 1);

  // Low-bit mask for the alignment check; works for ALIGN_BITS == 0 as well.
  localparam logic [XLEN-1:0] ALIGN_MASK = (XLEN'(1) << ALIGN_BITS) - XLEN'(1);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t            state_r;
  logic [CNT_W-1:0]  boot_cnt_r;
  logic              target_ok_s;

  // Sequential successor and redirect-target alignment check.
  always_comb begin
    pc_plus_step = pc + XLEN'(STEP);
    target_ok_s  = ((redirect_pc & ALIGN_MASK) == {XLEN{1'b0}});
  end

  // Control FSM plus all registered outputs (pc, epc, fetch_valid, misaligned, bad_addr).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_BOOT;
      boot_cnt_r  <= {CNT_W{1'b0}};
      pc          <= RESET_ADDR;
      epc         <= {XLEN{1'b0}};
      bad_addr    <= {XLEN{1'b0}};
      misaligned  <= 1'b0;
      fetch_valid <= 1'b0;
    end else begin
      // misaligned is a pulse: cleared every cycle unless re-raised below.
      misaligned <= 1'b0;
      case (state_r)
        ST_BOOT: begin
          // Control inputs are ignored while booting; pc stays at RESET_ADDR.
          if (boot_cnt_r == BOOT_LAST) begin
            state_r     <= ST_RUN;
            fetch_valid <= 1'b1;
          end else begin
            boot_cnt_r  <= boot_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        ST_RUN: begin
          if (halt) begin
            // Halt beats redirect/mret/stall; a trap is still taken.
            state_r     <= ST_HALT;
            fetch_valid <= 1'b0;
            if (trap) begin
              pc  <= trap_vector;
              epc <= trap_pc;
            end
          end else if (trap) begin
            pc  <= trap_vector;
            epc <= trap_pc;
          end else if (mret) begin
            pc <= epc;
          end else if (redirect) begin
            if (target_ok_s) begin
              pc <= redirect_pc;
            end else begin
              // Rejected target: fall through sequentially and report it.
              pc         <= pc_plus_step;
              misaligned <= 1'b1;
              bad_addr   <= redirect_pc;
            end
          end else if (!stall) begin
            pc <= pc_plus_step;
          end
        end
        ST_HALT: begin
          // Only trap can move pc while halted; leaving HALT keeps pc as is.
          if (trap) begin
            pc  <= trap_vector;
            epc <= trap_pc;
          end
          if (!halt) begin
            state_r     <= ST_RUN;
            fetch_valid <= 1'b1;
          end
        end
        default: begin
          // Unreachable encoding: restart the boot sequence.
          state_r     <= ST_BOOT;
          boot_cnt_r  <= {CNT_W{1'b0}};
          pc          <= RESET_ADDR;
          fetch_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
